// File: rtl/seg7_reader.sv
// Recovers hex digits from an active-low 7-segment pattern. The pattern must
// stay stable before it is decoded. Results are queued in a 4-entry FIFO.
module seg7_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [6:0] seg_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_digit,
  output logic       out_err,
  output logic [2:0] level,
  output logic       overflow,
  input  logic       clr_ovf
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [6:0]    ff1, s, last;
  logic [CW-1:0] cnt;
  logic          armed;
  logic          capture;

  logic          dec_err, dec_blank;
  logic [3:0]    dec_digit;

  logic [4:0]    mem [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    count;
  logic          push, pop, full, accept;

  // seg_in is asynchronous to CLOCK_50, so it passes through a two-flop synchroniser
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      ff1 <= 7'h7F;
      s   <= 7'h7F;
    end else begin
      ff1 <= seg_in;
      s   <= ff1;
    end
  end

  // A pattern fires once when it has been seen STABLE_CYCLES times; after that it must change before it can fire again
  assign capture = armed && (cnt == CNT_MAX);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      last  <= 7'h7F;
      cnt   <= '0;
      armed <= 1'b0;
    end else if (s != last) begin
      last  <= s;
      cnt   <= CW'(1);
      armed <= 1'b1;
    end else begin
      if (cnt < CNT_MAX) cnt <= cnt + CW'(1);
      if (capture) armed <= 1'b0;
    end
  end

  always_comb begin
    dec_digit = 4'h0;
    dec_err   = 1'b0;
    dec_blank = 1'b0;
    case (last)
      7'h40: dec_digit = 4'h0;
      7'h79: dec_digit = 4'h1;
      7'h24: dec_digit = 4'h2;
      7'h30: dec_digit = 4'h3;
      7'h19: dec_digit = 4'h4;
      7'h12: dec_digit = 4'h5;
      7'h02: dec_digit = 4'h6;
      7'h78: dec_digit = 4'h7;
      7'h00: dec_digit = 4'h8;
      7'h10: dec_digit = 4'h9;
      7'h08: dec_digit = 4'hA;
      7'h03: dec_digit = 4'hB;
      7'h46: dec_digit = 4'hC;
      7'h21: dec_digit = 4'hD;
      7'h06: dec_digit = 4'hE;
      7'h0E: dec_digit = 4'hF;
      7'h7F: dec_blank = 1'b1;
      default: dec_err = 1'b1;
    endcase
  end

  assign push   = capture && !dec_blank;
  assign pop    = out_valid && out_ready;
  assign full   = (count == 3'd4);
  // When the FIFO is full, a pop in the same cycle frees the slot that the push overwrites
  assign accept = push && (!full || pop);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= {dec_err, dec_digit};
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({accept, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
      else if (clr_ovf)         overflow <= 1'b0;
    end
  end

  assign level     = count;
  assign out_valid = (count != 3'd0);
  assign out_digit = out_valid ? mem[rd_ptr][3:0] : 4'h0;
  assign out_err   = out_valid ? mem[rd_ptr][4]   : 1'b0;

endmodule
